// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers with byte strobes.
// AW and W are captured independently; a single write may be outstanding, and the read path is a two-state FSM.
module axi_lite_slave_regfile #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          i_s_axi_awaddr,
    input  logic                           i_s_axi_awvalid,
    output logic                           o_s_axi_awready,
    input  logic [2:0]                     i_s_axi_awprot,
    input  logic [DATA_WIDTH-1:0]          i_s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_s_axi_wstrb,
    input  logic                           i_s_axi_wvalid,
    output logic                           o_s_axi_wready,
    output logic                           o_s_axi_bvalid,
    input  logic                           i_s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          i_s_axi_araddr,
    input  logic                           i_s_axi_arvalid,
    output logic                           o_s_axi_arready,
    input  logic [2:0]                     i_s_axi_arprot,
    output logic [DATA_WIDTH-1:0]          o_s_axi_rdata,
    output logic                           o_s_axi_rvalid,
    input  logic                           i_s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int BYTES  = DATA_WIDTH / 8;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [BYTES-1:0]      w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;

    r_state_t              r_state_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    logic                  aw_hs, w_hs, commit;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [BYTES-1:0]      commit_strb;
    logic [IDX_W-1:0]      aw_idx_in, ar_idx_in;
    logic [DATA_WIDTH-1:0] regs_arr [NUM_REGS];

    // Upper address bits and prot are decoded upstream; fold them here so nothing dangles.
    logic unused_ok;
    assign unused_ok = ^{i_s_axi_awaddr, i_s_axi_araddr, i_s_axi_awprot, i_s_axi_arprot};

    assign aw_idx_in = i_s_axi_awaddr[2 +: IDX_W];
    assign ar_idx_in = i_s_axi_araddr[2 +: IDX_W];

    assign o_s_axi_awready = !aw_held_q && !bvalid_q && !reset;
    assign o_s_axi_wready  = !w_held_q && !bvalid_q && !reset;
    assign o_s_axi_bvalid  = bvalid_q;
    assign o_s_axi_arready = (r_state_q == R_IDLE) && !reset;
    assign o_s_axi_rvalid  = rvalid_q;
    assign o_s_axi_rdata   = rdata_q;

    assign aw_hs  = i_s_axi_awvalid && o_s_axi_awready;
    assign w_hs   = i_s_axi_wvalid && o_s_axi_wready;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign commit_idx  = aw_held_q ? aw_idx_q : aw_idx_in;
    assign commit_data = w_held_q ? w_data_q : i_s_axi_wdata;
    assign commit_strb = w_held_q ? w_strb_q : i_s_axi_wstrb;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = aw_idx_in;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = i_s_axi_wdata;
                w_strb_d = i_s_axi_wstrb;
            end
        end
        // A commit cannot coincide with a B handshake: both halves are blocked while bvalid is high.
        if (bvalid_q && i_s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] reg_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    reg_q <= '0;
                end else if (commit && (commit_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (commit_strb[b]) begin
                            reg_q[b*8 +: 8] <= commit_data[b*8 +: 8];
                        end
                    end
                end
            end

            assign regs_arr[gi]                          = reg_q;
            assign o_regs[gi*DATA_WIDTH +: DATA_WIDTH]   = reg_q;
        end
    endgenerate

    // rdata samples the pre-commit register value when a read and a write land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (i_s_axi_arvalid) begin
                        rdata_q   <= regs_arr[ar_idx_in];
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile: write ordering, back-pressure, reads, collisions and reset.
module tb_axi_lite_slave_regfile;

    localparam int NUM_REGS   = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    logic                           clk = 1'b0;
    logic                           reset;
    logic [ADDR_WIDTH-1:0]          awaddr;
    logic                           awvalid;
    logic                           awready;
    logic [2:0]                     awprot;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [DATA_WIDTH/8-1:0]        wstrb;
    logic                           wvalid;
    logic                           wready;
    logic                           bvalid;
    logic                           bready;
    logic [ADDR_WIDTH-1:0]          araddr;
    logic                           arvalid;
    logic                           arready;
    logic [2:0]                     arprot;
    logic [DATA_WIDTH-1:0]          rdata;
    logic                           rvalid;
    logic                           rready;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    axi_lite_slave_regfile #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_s_axi_awaddr  (awaddr),
        .i_s_axi_awvalid (awvalid),
        .o_s_axi_awready (awready),
        .i_s_axi_awprot  (awprot),
        .i_s_axi_wdata   (wdata),
        .i_s_axi_wstrb   (wstrb),
        .i_s_axi_wvalid  (wvalid),
        .o_s_axi_wready  (wready),
        .o_s_axi_bvalid  (bvalid),
        .i_s_axi_bready  (bready),
        .i_s_axi_araddr  (araddr),
        .i_s_axi_arvalid (arvalid),
        .o_s_axi_arready (arready),
        .i_s_axi_arprot  (arprot),
        .o_s_axi_rdata   (rdata),
        .o_s_axi_rvalid  (rvalid),
        .i_s_axi_rready  (rready),
        .o_regs          (regs)
    );

    // Advance one rising edge and settle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_at(input int k);
        return regs[k*32 +: 32];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        check_count++;
        if ({awready, wready, arready} !== 3'b000) $display("FAIL reset_ready: got %b want 000", {awready, wready, arready});
        else pass_count++;
        reset = 1'b0;
        #1;
        check_count++;
        if ({awready, wready, arready} !== 3'b111) $display("FAIL post_reset_ready: got %b want 111", {awready, wready, arready});
        else pass_count++;
        check_count++;
        if ({bvalid, rvalid} !== 2'b00) $display("FAIL reset_valids: got %b want 00", {bvalid, rvalid});
        else pass_count++;
        check_count++;
        if (regs !== '0) $display("FAIL reset_regs: got %h want 0", regs);
        else pass_count++;
        check_count++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata);
        else pass_count++;
        $display("reset applied and released");
    endtask

    task automatic test_simultaneous_write();
        awaddr = 32'h08; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_count++;
        if (bvalid !== 1'b1) $display("FAIL simul_bvalid: got %b want 1", bvalid);
        else pass_count++;
        check_count++;
        if (reg_at(2) !== 32'hDEADBEEF) $display("FAIL simul_reg2: got %h want deadbeef", reg_at(2));
        else pass_count++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_count++;
        if (bvalid !== 1'b0) $display("FAIL simul_bclear: got %b want 0", bvalid);
        else pass_count++;
        $display("write addr=0x08 data=deadbeef strb=f");
    endtask

    task automatic test_w_before_aw();
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_count++;
            if (wready !== 1'b0 || bvalid !== 1'b0) $display("FAIL wfirst_wait%0d: got wready=%b bvalid=%b want 0 0", i, wready, bvalid);
            else pass_count++;
            tick();
        end
        check_count++;
        if (reg_at(1) !== 32'h0) $display("FAIL wfirst_uncommitted: got %h want 0", reg_at(1));
        else pass_count++;
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check_count++;
        if (bvalid !== 1'b1) $display("FAIL wfirst_bvalid: got %b want 1", bvalid);
        else pass_count++;
        check_count++;
        if (reg_at(1) !== 32'h00220044) $display("FAIL wfirst_reg1: got %h want 00220044", reg_at(1));
        else pass_count++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        $display("write W-first addr=0x04 data=11223344 strb=5");
    endtask

    task automatic test_back_to_back();
        awaddr = 32'h10; awvalid = 1'b1;
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        wvalid = 1'b0;
        awaddr = 32'h14;
        for (int i = 0; i < 5; i++) begin
            check_count++;
            if ({bvalid, awready, wready} !== 3'b100) $display("FAIL bp_cycle%0d: got bvalid/awready/wready=%b want 100", i, {bvalid, awready, wready});
            else pass_count++;
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_count++;
        if ({bvalid, awready} !== 2'b01) $display("FAIL bp_after_b: got bvalid/awready=%b want 01", {bvalid, awready});
        else pass_count++;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_count++;
        if (reg_at(5) !== 32'h12345678 || reg_at(4) !== 32'hA5A5A5A5) $display("FAIL bp_second: got reg5=%h reg4=%h want 12345678 a5a5a5a5", reg_at(5), reg_at(4));
        else pass_count++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        $display("write back-pressure addr=0x10 then addr=0x14");
    endtask

    task automatic test_read();
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'hDEADBEEF)
                $display("FAIL read_hold%0d: got rvalid=%b arready=%b rdata=%h want 1 0 deadbeef", i, rvalid, arready, rdata);
            else pass_count++;
            if (i < 3) tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_count++;
        if ({rvalid, arready} !== 2'b01) $display("FAIL read_idle: got rvalid/arready=%b want 01", {rvalid, arready});
        else pass_count++;
        $display("read addr=0x08 data=%h", rdata);
    endtask

    task automatic test_collision();
        awaddr = 32'h0C; awvalid = 1'b1;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        awvalid = 1'b1; wdata = 32'h2; wvalid = 1'b1;
        araddr = 32'h0C; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_count++;
        if (rdata !== 32'h1) $display("FAIL coll_old: got %h want 00000001", rdata);
        else pass_count++;
        check_count++;
        if (reg_at(3) !== 32'h2) $display("FAIL coll_reg3: got %h want 00000002", reg_at(3));
        else pass_count++;
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check_count++;
        if (rdata !== 32'h2) $display("FAIL coll_new: got %h want 00000002", rdata);
        else pass_count++;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        $display("read/write collision addr=0x0C");
    endtask

    task automatic test_reset_mid_write();
        awaddr = 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check_count++;
        if ({bvalid, awready, wready} !== 3'b001) $display("FAIL midrst_held: got bvalid/awready/wready=%b want 001", {bvalid, awready, wready});
        else pass_count++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check_count++;
        if (bvalid !== 1'b0) $display("FAIL midrst_bvalid: got %b want 0", bvalid);
        else pass_count++;
        check_count++;
        if (regs !== '0) $display("FAIL midrst_regs: got %h want 0", regs);
        else pass_count++;
        $display("reset mid-write addr=0x18");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        awaddr = '0; awvalid = 1'b0; awprot = 3'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; arprot = 3'b0; rready = 1'b0;
        test_reset();
        test_simultaneous_write();
        test_w_before_aw();
        test_back_to_back();
        test_read();
        test_collision();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
